// File: rtl/tdm_pkg.sv
// tdm_pkg: frame format and state encoding shared by both ends of the TDM path
package tdm_pkg;
   localparam int TDM_NCH = 4;
   localparam int TDM_SW  = 8;
   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} tdm_state_e;
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial input and per-channel output bundle of the TDM demux
interface tdm_demux_if import tdm_pkg::*; #(
   parameter int NCH = TDM_NCH,
   parameter int SW  = TDM_SW
);
   logic              en;
   logic              din;
   logic              fsync;
   logic [NCH*SW-1:0] dout;
   logic [NCH-1:0]    dvalid;
   logic              frame_done;
   logic              sync_err;
   logic              locked;
   modport master (output en, din, fsync, input dout, dvalid, frame_done, sync_err, locked);
   modport slave  (input en, din, fsync, output dout, dvalid, frame_done, sync_err, locked);
endinterface

// File: rtl/tdm_sipo.sv
// tdm_sipo: serial-in/parallel-out shift register; the parallel word includes the bit being sampled
module tdm_sipo #(
   parameter int SW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          din,
   output logic [SW-1:0] q
);
   logic [SW-2:0] r;
   assign q = {r, din};
   // keep the newest SW-1 accepted bits, MSB first
   always_ff @(posedge clk or posedge rst)
      if (rst) r <= '0;
      else if (en) r <= q[SW-2:0];
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: splits a framed serial TDM stream into registered per-channel words
module tdm_demux import tdm_pkg::*; #(
   parameter int NCH = TDM_NCH,
   parameter int SW  = TDM_SW
) (
   input logic        clk,
   input logic        rst,
   tdm_demux_if.slave bus
);
   localparam int CW = $clog2(NCH);
   localparam int BW = $clog2(SW);
   tdm_state_e        state;
   logic [CW-1:0]     slot_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [SW-1:0]     word;
   logic [NCH*SW-1:0] dout;
   logic [NCH-1:0]    dvalid;
   logic              frame_done, sync_err, at_bound, last_bit, last_slot, sh_en;
   // frame position decode; a bit is shifted unless it is thrown away while hunting or on a lost sync
   always_comb begin
      at_bound  = bit_cnt == '0 && slot_cnt == '0;
      last_bit  = bit_cnt == BW'(SW - 1);
      last_slot = slot_cnt == CW'(NCH - 1);
      sh_en     = bus.en && (state == HUNT ? bus.fsync : bus.fsync || !at_bound);
   end
   tdm_sipo #(.SW(SW)) u_sipo (
      .clk (clk),
      .rst (rst),
      .en  (sh_en),
      .din (bus.din),
      .q   (word)
   );
   // lock FSM, slot/bit counters and registered channel outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= HUNT;
         slot_cnt   <= '0;
         bit_cnt    <= '0;
         dout       <= '0;
         dvalid     <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         dvalid     <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (bus.en) begin
            if (state == HUNT) begin
               if (bus.fsync) begin
                  state    <= RUN;
                  bit_cnt  <= BW'(1);
                  slot_cnt <= '0;
               end
            end else if (at_bound) begin
               if (bus.fsync) bit_cnt <= BW'(1);
               else begin
                  sync_err <= 1'b1;
                  state    <= HUNT;
               end
            end else if (bus.fsync) begin
               sync_err <= 1'b1;
               bit_cnt  <= BW'(1);
               slot_cnt <= '0;
            end else if (last_bit) begin
               bit_cnt    <= '0;
               slot_cnt   <= last_slot ? '0 : slot_cnt + 1'b1;
               frame_done <= last_slot;
               for (int k = 0; k < NCH; k++)
                  if (slot_cnt == CW'(k)) begin
                     dout[k*SW +: SW] <= word;
                     dvalid[k]        <= 1'b1;
                  end
            end else bit_cnt <= bit_cnt + 1'b1;
         end
      end
   assign bus.dout       = dout;
   assign bus.dvalid     = dvalid;
   assign bus.frame_done = frame_done;
   assign bus.sync_err   = sync_err;
   assign bus.locked     = state == RUN;
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer; the receive end of the team's serial TDM mux path.
- Takes a 1-bit serial stream framed by a frame-sync strobe and distributes each slot to its own parallel output channel.
- Each output is a registered word with a one-cycle valid pulse.
- Sits between the serial line front end and per-channel consumers.

Parameters:
- NCH, 4, number of channels (slots per frame); legal 2..8.
- SW, 8, bits per slot; legal 2..16.
- CW, $clog2(NCH), slot counter width (derived, not overridden).
- BW, $clog2(SW), bit counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit enable; din/fsync are sampled only when en=1.
- din  input  1  serial data, MSB of each slot first.
- fsync  input  1  frame sync; high on the bit cycle carrying slot 0, bit 0 (MSB).
- dout  output  NCH*SW  channel words; channel k occupies bits [k*SW +: SW].
- dvalid  output  NCH  one-hot pulse; bit k is high for one cycle when dout channel k updates.
- frame_done  output  1  one-cycle pulse after the last bit of slot NCH-1.
- sync_err  output  1  one-cycle pulse on a framing violation.
- locked  output  1  high while in RUN.

Behaviour:
- Reset (async, any time, including mid-frame):
  - dout=0, dvalid=0, frame_done=0, sync_err=0, locked=0.
  - Counters=0, shift register=0, state=HUNT.
- States:
  - HUNT: discard bits. An en=1 cycle with fsync=1 takes that bit as slot 0 bit 0, sets bit counter to 1, and moves to RUN.
  - RUN: every en=1 cycle shifts din into the shift register (MSB first) and advances the bit counter. At bit SW-1 the bit counter wraps to 0 and the slot counter increments. After slot NCH-1 the slot counter wraps to 0.
- en=0:
  - Counters, state, shift register and dout hold.
  - dvalid, frame_done and sync_err are 0.
- Slot completion: the edge that samples bit SW-1 of slot k loads {shift[SW-2:0], din} into dout channel k. dvalid[k]=1 for exactly the following cycle. Other channels hold their values.
- Frame completion: frame_done=1 in the same cycle as dvalid[NCH-1].
- Frame boundary check (slot 0, bit 0 expected):
  - fsync=1: normal; frame continues.
  - fsync=0: sync_err pulse; state→HUNT; the bit is discarded; locked falls the next cycle.
- fsync=1 at any other bit in RUN (mid-frame):
  - sync_err pulse.
  - The partial slot is discarded: no dvalid for it, and its dout channel holds its previous value.
  - That bit restarts the frame as slot 0 bit 0; state stays RUN.
- fsync=1 in HUNT never raises sync_err.
- A frame is accepted and output even if followed by a missing sync: dvalid/frame_done for that frame still fire, then sync_err is raised on the next frame's bit 0.
- Latency: the last bit of a slot is sampled at edge N; its channel word is visible, with dvalid high, in the cycle after edge N.
- No arithmetic beyond counter wrap; counters compare against SW-1 and NCH-1, never rely on power-of-2 overflow.

Decomposition:
- Shared package tdm_pkg:
  - State encoding constants (HUNT=1'b0, RUN=1'b1).
  - Default NCH/SW constants, shared with the TDM mux so both ends agree on the frame format.
- One sub-module: tdm_sipo, an SW-bit serial-in/parallel-out shift register with enable and async reset.
- Counters, FSM and output registers stay in tdm_demux.

Test Plan:
- Reset, no fsync: NCH=4, SW=8, en=1, random din for 50 cycles → dout=0, dvalid=0, locked=0, sync_err=0 throughout.
- Basic frame: fsync with slots A5,3C,FF,00, en=1 continuous, fsync sampled in cycle 0:
  - dvalid=0001 in cycle 8, 0010 in cycle 16, 0100 in cycle 24, 1000 in cycle 32.
  - dout=0x00FF3CA5 after cycle 32.
  - frame_done=1 in cycle 32 only.
- Stall: same frame with en toggling 1,0,1,0 → identical dout/dvalid sequence at twice the latency; no pulses during en=0 cycles.
- Lost sync: second frame begins with fsync=0 → sync_err=1 one cycle, locked=0 the next cycle. Next frame with fsync=1 relocks; slot 0 value 0x81 → dvalid[0] and dout[7:0]=0x81.
- Mid-frame sync: fsync=1 at slot 1 bit 3 → sync_err pulse, no dvalid[1], dout[15:8] keeps its old value. The new frame is decoded from that bit onward.
- Async reset mid-frame at slot 2 bit 5 → all outputs 0 immediately without a clock edge; HUNT on release.
